// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and default rate constants.
// StParity exists only when UART_RX_PARITY_EN is defined.
package uart_pkg;

    localparam int unsigned UART_CLK_DIV_115200_50M = 27;
    localparam int unsigned UART_OVERSAMPLE         = 16;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
`ifdef UART_RX_PARITY_EN
        StParity,
`endif
        StStop,
        StBreak
    } uart_state_e;

endpackage

// File: rtl/uart_tick_gen.sv
// Free-running oversample tick generator: one-cycle tick every CLK_DIV clocks.
// Shared between the UART receiver and transmitter.
module uart_tick_gen #(
    parameter int unsigned CLK_DIV = 27
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    localparam int unsigned CntW = $clog2(CLK_DIV);
    localparam logic [CntW-1:0] CntMax = CntW'(CLK_DIV - 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    assign tick = (cnt_q == CntMax);

    always_comb begin
        cnt_d = tick ? '0 : cnt_q + CntW'(1);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_rx_os.sv
// Oversampling UART receiver: 2-flop synchroniser, mid-bit sampling, LSB-first shift.
// Define UART_RX_PARITY_EN to add one even-parity bit after the data bits.
module uart_rx_os
    import uart_pkg::*;
#(
    parameter int unsigned CLK_DIV    = UART_CLK_DIV_115200_50M,
    parameter int unsigned OVERSAMPLE = UART_OVERSAMPLE,
    parameter int unsigned DATA_BITS  = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 Rx,
    output logic [DATA_BITS-1:0] data,
    output logic                 valid,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 busy,
    output logic                 sample_tick
);

    localparam int unsigned OsW  = $clog2(OVERSAMPLE);
    localparam int unsigned IdxW = $clog2(DATA_BITS);
    localparam logic [OsW-1:0]  OsMid   = OsW'(OVERSAMPLE / 2 - 1);
    localparam logic [OsW-1:0]  OsLast  = OsW'(OVERSAMPLE - 1);
    localparam logic [IdxW-1:0] IdxLast = IdxW'(DATA_BITS - 1);

    logic                 tick;
    logic                 rx_meta_q, rx_s_q;
    uart_state_e          state_q, state_d;
    logic [OsW-1:0]       os_cnt_q, os_cnt_d;
    logic [IdxW-1:0]      bit_idx_q, bit_idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 frame_err_q, frame_err_d;
`ifdef UART_RX_PARITY_EN
    logic                 par_bad_q, par_bad_d;
    logic                 par_err_q, par_err_d;
`endif

    uart_tick_gen #(
        .CLK_DIV(CLK_DIV)
    ) u_tick_gen (
        .clk  (clk),
        .rst_n(rst_n),
        .tick (tick)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= Rx;
            rx_s_q    <= rx_meta_q;
        end
    end

    always_comb begin
        state_d     = state_q;
        os_cnt_d    = os_cnt_q;
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        data_d      = data_q;
        valid_d     = 1'b0;
        frame_err_d = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bad_d   = par_bad_q;
        par_err_d   = 1'b0;
`endif
        if (tick) begin
            os_cnt_d = os_cnt_q + OsW'(1);
            unique case (state_q)
                StIdle: begin
                    if (!rx_s_q) begin
                        state_d  = StStart;
                        os_cnt_d = '0;
                    end
                end
                StStart: begin
                    if (os_cnt_q == OsMid) begin
                        os_cnt_d  = '0;
                        bit_idx_d = '0;
                        state_d   = rx_s_q ? StIdle : StData;
                    end
                end
                StData: begin
                    if (os_cnt_q == OsLast) begin
                        os_cnt_d  = '0;
                        shift_d   = {rx_s_q, shift_q[DATA_BITS-1:1]};
                        bit_idx_d = bit_idx_q + IdxW'(1);
                        if (bit_idx_q == IdxLast) begin
`ifdef UART_RX_PARITY_EN
                            state_d = StParity;
`else
                            state_d = StStop;
`endif
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                StParity: begin
                    if (os_cnt_q == OsLast) begin
                        os_cnt_d  = '0;
                        par_bad_d = ((^shift_q) != rx_s_q);
                        state_d   = StStop;
                    end
                end
`endif
                StStop: begin
                    if (os_cnt_q == OsLast) begin
                        os_cnt_d = '0;
`ifdef UART_RX_PARITY_EN
                        par_err_d = par_bad_q;
`endif
                        if (rx_s_q) begin
                            data_d  = shift_q;
                            valid_d = 1'b1;
                            state_d = StIdle;
                        end else begin
                            frame_err_d = 1'b1;
                            state_d     = StBreak;
                        end
                    end
                end
                // Wait for the line to go high so a held-low line cannot restart a frame.
                StBreak: begin
                    if (rx_s_q) begin
                        state_d = StIdle;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            os_cnt_q    <= '0;
            bit_idx_q   <= '0;
            shift_q     <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad_q   <= 1'b0;
            par_err_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            os_cnt_q    <= os_cnt_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            frame_err_q <= frame_err_d;
`ifdef UART_RX_PARITY_EN
            par_bad_q   <= par_bad_d;
            par_err_q   <= par_err_d;
`endif
        end
    end

    assign data        = data_q;
    assign valid       = valid_q;
    assign frame_err   = frame_err_q;
`ifdef UART_RX_PARITY_EN
    assign parity_err  = par_err_q;
`else
    assign parity_err  = 1'b0;
`endif
    assign busy        = (state_q != StIdle);
    assign sample_tick = tick;

endmodule

// File: tb/tb_uart_rx_os.sv
// Scoreboard bench for uart_rx_os: frames are modelled at bit level, strobes checked by a monitor.
// Honours UART_RX_PARITY_EN the same way as the design.
module tb_uart_rx_os;

    localparam int unsigned CLK_DIV = 4;
    localparam int unsigned OS      = 16;
    localparam int unsigned DB      = 8;
    localparam int          BIT_CYC = CLK_DIV * OS;
`ifdef UART_RX_PARITY_EN
    localparam int PAR_BITS = 1;
`else
    localparam int PAR_BITS = 0;
`endif
    // Start edge to strobe is about (1 + DB + parity + 0.5) bit periods.
    localparam int LAT_NOM = (2 * (1 + DB + PAR_BITS) + 1) * BIT_CYC / 2;
    localparam int LAT_MIN = LAT_NOM - 4;
    localparam int LAT_MAX = LAT_NOM + 2 * CLK_DIV + 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          Rx = 1'b1;
    logic [DB-1:0] data;
    logic          valid, frame_err, parity_err, busy, sample_tick;

    typedef struct {
        logic [DB-1:0] data;
        bit            fe;
        bit            pe;
        int            t0;
    } exp_t;

    exp_t          exp_q[$];
    exp_t          e_mon;
    int            checks = 0;
    int            errors = 0;
    int            cyc = 0;
    int            lat;
    logic [DB-1:0] last_good = '0;

    uart_rx_os #(
        .CLK_DIV   (CLK_DIV),
        .OVERSAMPLE(OS),
        .DATA_BITS (DB)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .Rx         (Rx),
        .data       (data),
        .valid      (valid),
        .frame_err  (frame_err),
        .parity_err (parity_err),
        .busy       (busy),
        .sample_tick(sample_tick)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every strobe cycle consumes exactly one expected frame.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                last_good = '0;
            end else if (valid || frame_err || parity_err) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_strobe: valid=%0b frame_err=%0b parity_err=%0b, none expected (cycle %0d)",
                             valid, frame_err, parity_err, cyc);
                end else begin
                    e_mon = exp_q.pop_front();
                    check("valid", 32'(valid), 32'(!e_mon.fe));
                    check("frame_err", 32'(frame_err), 32'(e_mon.fe));
                    check("parity_err", 32'(parity_err), 32'(e_mon.pe));
                    check("data", 32'(data), 32'(e_mon.fe ? last_good : e_mon.data));
                    if (!e_mon.fe) last_good = e_mon.data;
                    lat = cyc - e_mon.t0;
                    checks++;
                    if (lat < LAT_MIN || lat > LAT_MAX) begin
                        errors++;
                        $display("FAIL latency: got %0d cycles, expected %0d..%0d", lat, LAT_MIN, LAT_MAX);
                    end
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // All stimulus tasks start and end 1 time unit after a rising edge.
    task automatic drive_bit(input logic b);
        Rx = b;
        repeat (BIT_CYC) @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        Rx = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [DB-1:0] d, input bit par, input bit stop);
        exp_t e;
        e.data = d;
        e.fe   = !stop;
`ifdef UART_RX_PARITY_EN
        e.pe   = ((^d) != par);
`else
        e.pe   = 1'b0;
`endif
        e.t0   = cyc;
        exp_q.push_back(e);
        drive_bit(1'b0);
        for (int i = 0; i < DB; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
        drive_bit(par);
`endif
        drive_bit(stop);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_data"}, 32'(data), 32'h0);
        check({tag, "_valid"}, 32'(valid), 32'h0);
        check({tag, "_frame_err"}, 32'(frame_err), 32'h0);
        check({tag, "_parity_err"}, 32'(parity_err), 32'h0);
        check({tag, "_busy"}, 32'(busy), 32'h0);
        check({tag, "_sample_tick"}, 32'(sample_tick), 32'h0);
    endtask

    initial begin
        logic [DB-1:0] d;
        bit            stop, par, seen, all_busy;
        int            tick_cnt, waited;

        // Reset state
        repeat (4) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Divider period
        tick_cnt = 0;
        repeat (400) begin
            @(negedge clk);
            if (sample_tick) tick_cnt++;
        end
        check("tick_count", 32'(tick_cnt), 32'(400 / CLK_DIV));
        @(posedge clk);
        #1;
        idle(BIT_CYC);

        // Good frame
        send_frame(8'hA5, ^8'hA5, 1'b1);
        idle(2 * BIT_CYC);
        check("good_drained", 32'(exp_q.size()), 32'h0);

        // Reset in the middle of the data bits
        d = 8'h3C;
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(d[i]);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_all_zero("midreset");
        Rx = 1'b1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(2 * BIT_CYC);
        send_frame(8'h3C, ^8'h3C, 1'b1);
        idle(BIT_CYC);

        // Back-to-back
        send_frame(8'h00, 1'b0, 1'b1);
        send_frame(8'hFF, ^8'hFF, 1'b1);
        idle(2 * BIT_CYC);
        check("b2b_drained", 32'(exp_q.size()), 32'h0);

        // Glitch shorter than half a bit
        seen = 1'b0;
        Rx = 1'b0;
        repeat (20) begin
            @(posedge clk);
            #1;
            seen |= busy;
        end
        idle(60);
        check("glitch_busy_seen", 32'(seen), 32'h1);
        check("glitch_busy_after", 32'(busy), 32'h0);

        // Framing error followed by a long break
        send_frame(8'h55, ^8'h55, 1'b0);
        all_busy = 1'b1;
        repeat (2000) begin
            @(posedge clk);
            #1;
            all_busy &= busy;
        end
        check("break_busy_held", 32'(all_busy), 32'h1);
        check("break_strobe_seen", 32'(exp_q.size()), 32'h0);
        idle(3 * CLK_DIV + 4);
        check("break_busy_released", 32'(busy), 32'h0);
        idle(BIT_CYC);

`ifdef UART_RX_PARITY_EN
        send_frame(8'h07, 1'b0, 1'b1);
        idle(BIT_CYC);
        send_frame(8'h07, 1'b1, 1'b1);
        idle(BIT_CYC);
`endif

        // Randomized frames, stop and parity bits occasionally wrong
        for (int n = 0; n < 16; n++) begin
            d    = DB'($urandom);
            stop = ($urandom_range(3) != 0);
            par  = ($urandom_range(3) != 0) ? (^d) : !(^d);
            send_frame(d, par, stop);
            idle(int'($urandom_range(0, BIT_CYC)) + (stop ? 0 : BIT_CYC));
        end

        idle(2 * BIT_CYC);
        waited = 0;
        while (exp_q.size() != 0 && waited < 4 * BIT_CYC) begin
            @(posedge clk);
            waited++;
        end
        check("scoreboard_drained", 32'(exp_q.size()), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_rx_os.md
# uart_rx_os

Parametrised oversampling UART receiver for the keyboard/piano front end. It generates its own sample tick from the system clock with a configurable divider, and synchronises the asynchronous `Rx` line. It validates the start bit at mid-bit, shifts in a configurable number of data bits LSB first, and checks the stop bit. Each byte is delivered with a one-cycle valid strobe and error flags to the downstream note decoder.

## Interface
- `CLK_DIV`, 27: system clocks per oversample tick (50 MHz / 115200 / 16 ≈ 27); legal range ≥ 2.
- `OVERSAMPLE`, 16: ticks per bit; must be even and ≥ 4.
- `DATA_BITS`, 8: data bits per frame, 5..9.
- `clk`  in  1: the single system clock.
- `rst_n`  in  1: synchronous, active-low reset, sampled on `posedge clk`.
- `Rx`  in  1: asynchronous serial line, idle high.
- `data`  out  DATA_BITS: last received word; held until the next good frame.
- `valid`  out  1: one-cycle pulse when `data` is updated.
- `frame_err`  out  1: one-cycle pulse when the stop bit is sampled low.
- `parity_err`  out  1: one-cycle pulse on parity mismatch (tied 0 without the macro).
- `busy`  out  1: high in every state except IDLE.
- `sample_tick`  out  1: the oversample tick, exported for debug and scope triggering.

## Operation
- Reset (`rst_n`=0 at a clock edge) sets the following and overrides everything, including mid-frame:
  - outputs: `data`=0, `valid`=0, `frame_err`=0, `parity_err`=0, `busy`=0, `sample_tick`=0;
  - internal: divider=0, state=IDLE, synchroniser flops=1.
- `Rx` passes through a 2-flop synchroniser (reset value 1) to give `rx_s`. All decisions use `rx_s`.
- Divider: counts 0..CLK_DIV-1. `sample_tick`=1 for exactly one cycle when the count equals CLK_DIV-1, then the count wraps to 0. The divider is free-running; there is no re-alignment on a start edge.
- State machine transitions are taken only on tick cycles. A tick counter `os_cnt` (width clog2(OVERSAMPLE)) and a bit index are kept.
  - IDLE: if `rx_s`=0 on a tick → START, `os_cnt`=0.
  - START: on the tick where `os_cnt`=OVERSAMPLE/2-1, sample `rx_s`.
    - 0 → DATA, `os_cnt`=0, bit index=0.
    - 1 → IDLE. This is a glitch; no error is flagged.
  - DATA: on the tick where `os_cnt`=OVERSAMPLE-1, shift `rx_s` into the MSB of the shift register (LSB-first reception) and clear `os_cnt`.
    - After DATA_BITS samples → PARITY (macro defined) or STOP.
  - PARITY: sample on the same mid-bit rule as DATA, then → STOP.
  - STOP: sample on the same rule.
    - 1 → load `data` from the shift register, pulse `valid`, → IDLE.
    - 0 → pulse `frame_err`, leave `data` unchanged, → BREAK.
  - BREAK: on a tick with `rx_s`=1 → IDLE. This prevents a held-low line from re-triggering START.
- A parity mismatch pulses `parity_err` in the same cycle as `valid`. `data` is still loaded.
- `frame_err` and `parity_err` may pulse together. `valid` never coincides with `frame_err`.

## Timing
- Tick period is CLK_DIV cycles. Bit period is CLK_DIV·OVERSAMPLE cycles.
- Synchroniser delay: 2 cycles from `Rx` to `rx_s`.
- Start detection jitter is up to one tick, because the divider is free-running.
- `valid`/`frame_err`/`parity_err` are registered. They assert on the clock edge after the tick cycle that samples the stop bit, and are high for exactly one cycle.
- `busy` rises on the edge after the start-detect tick. It falls on the same edge as the `valid` pulse, or on leaving BREAK.
- Frame latency, from the first `rx_s` low to `valid`: about (1 + DATA_BITS [+1 parity] + 0.5)·OVERSAMPLE ticks.
- Back-to-back frames are supported. IDLE accepts a new start bit on the first tick after STOP.

## Configuration
- `UART_RX_PARITY_EN` defined:
  - one even-parity bit follows the data bits;
  - expected parity = XOR of the data bits;
  - mismatch → `parity_err`.
- Undefined:
  - no PARITY state exists;
  - the frame is start + DATA_BITS + stop;
  - `parity_err` is constant 0.

## Structure
- Shared package `uart_pkg`:
  - state enum (IDLE, START, DATA, PARITY, STOP, BREAK);
  - default constants `UART_CLK_DIV_115200_50M`=27 and `UART_OVERSAMPLE`=16.
- Sub-module `uart_tick_gen` (parameter CLK_DIV; ports `clk`, `rst_n`, `tick`). It is reusable by the future transmitter.

## Test plan
Bench parameters: CLK_DIV=4, OVERSAMPLE=16, DATA_BITS=8, so one bit lasts 64 cycles.
- Reset mid-frame: drive `rst_n`=0 halfway through the data bits of 0x3C → all outputs 0 next edge, `busy`=0. A following clean 0x3C frame is received correctly.
- Good frame: send 0xA5 with stop=1 → `data`=8'hA5 and exactly one `valid` cycle about 600 cycles after the start edge. `frame_err`=0.
- Back-to-back: send 0x00 then 0xFF with no idle gap → two `valid` pulses, `data` 0x00 then 0xFF.
- Glitch: pulse `Rx` low for 20 cycles → no state change beyond START, `busy` returns to 0, and no strobe.
- Framing/break: send 0x55 with stop=0, then hold `Rx` low for 2000 cycles → one `frame_err` pulse, `data` unchanged, `busy` high until `Rx` returns high.
- Parity (macro defined): send 0x07 with parity bit 0 → `valid` and `parity_err` pulse together. Send 0x07 with parity bit 1 → `valid` only.
